// File: rtl/sample_sequencer.sv
// sample_sequencer
//   Walks the enabled mux channels (lowest index first). For each channel it
//   switches ch_sel, waits SETTLE cycles, then emits n_samples one-cycle
//   strobes spaced div_cfg+1 cycles apart. Ends with a one-cycle done pulse.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   start               : one-cycle request (accepted in IDLE with nonzero mask/count)
//   abort               : level, returns to IDLE without done
//   div_cfg/n_samples/ch_mask : configuration, latched on accepted start
//   busy                : any state but IDLE
//   ch_sel              : current mux channel
//   sample_en           : one-cycle sample strobe for ch_sel
//   sample_idx          : strobe index within channel, valid with sample_en
//   done                : one-cycle pulse after the last channel completes
//
// All outputs come straight from flops. Output flops are loaded from the
// next-state values so that each output reflects the state of the cycle it
// is visible in.
module sample_sequencer #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 12,
  parameter int SETTLE = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [DIV_W-1:0]          div_cfg,
  input  logic [CNT_W-1:0]          n_samples,
  input  logic [NUM_CH-1:0]         ch_mask,
  output logic                      busy,
  output logic [$clog2(NUM_CH)-1:0] ch_sel,
  output logic                      sample_en,
  output logic [CNT_W-1:0]          sample_idx,
  output logic                      done
);

  localparam int CW = $clog2(NUM_CH);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_RUN, S_NEXT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     ch_sel_q, ch_sel_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              sample_en_q, sample_en_d;
  logic              done_q, done_d;

  logic              nxt_found;
  logic [CW-1:0]     nxt_ch;
  logic [CW-1:0]     first_ch;
  logic              accept;
  logic              wrap;

  always_comb begin
    state_d  = state_q;
    ch_sel_d = ch_sel_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    div_d    = div_q;
    n_d      = n_q;
    mask_d   = mask_q;
    last_d   = last_q;

    // Next enabled channel above the current one (lowest such index wins).
    nxt_found = 1'b0;
    nxt_ch    = ch_sel_q;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch_sel_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = CW'(i);
      end
    end

    // First channel of a new sequence comes from the live mask input.
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_ch = CW'(i);
    end

    accept = start && !abort && (ch_mask != '0) && (n_samples != '0);
    wrap   = (cnt_q == div_q);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          div_d    = div_cfg;
          n_d      = n_samples;
          mask_d   = ch_mask;
          ch_sel_d = first_ch;
          state_d  = (SETTLE == 0) ? S_RUN : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = S_RUN;
        else                         settle_d = settle_q + SW'(1);
      end
      S_RUN: begin
        cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
        if (wrap) begin
          if (idx_q == n_q - CNT_W'(1)) begin
            // Switch the mux as we leave RUN so the new channel is
            // already selected during the NEXT cycle.
            state_d = S_NEXT;
            last_d  = !nxt_found;
            if (nxt_found) ch_sel_d = nxt_ch;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      S_NEXT: begin
        if (last_q) state_d = S_DONE;
        else        state_d = (SETTLE == 0) ? S_RUN : S_SETTLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything else in the sequence, including a due strobe.
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      ch_sel_d = ch_sel_q;
    end

    if ((state_d == S_RUN) && (state_q != S_RUN)) begin
      cnt_d = '0;
      idx_d = '0;
    end
    if ((state_d == S_SETTLE) && (state_q != S_SETTLE)) settle_d = '0;

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    sample_en_d = (state_d == S_RUN) && (cnt_d == div_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_sel_q    <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      settle_q    <= '0;
      div_q       <= '0;
      n_q         <= '0;
      mask_q      <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      sample_en_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_sel_q    <= ch_sel_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      div_q       <= div_d;
      n_q         <= n_d;
      mask_q      <= mask_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      sample_en_q <= sample_en_d;
      done_q      <= done_d;
    end
  end

  assign busy       = busy_q;
  assign ch_sel     = ch_sel_q;
  assign sample_en  = sample_en_q;
  assign sample_idx = idx_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// Scoreboard bench for sample_sequencer. Two instances share the stimulus:
// u0 with SETTLE=15 and u1 with SETTLE=0. A reference model turns every
// accepted start into a list of expected (cycle, channel, index) strobes plus
// a busy window and done cycle; a negedge monitor pops and compares.
// Cycle numbering: cyc counts rising edges; a start driven while cyc==c is
// sampled at edge e=c+1, and outputs loaded at edge e are seen while cyc==e.
module tb_sample_sequencer;
  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] div_cfg;
  logic [11:0] n_samples;
  logic [3:0]  ch_mask;
  logic        busy      [NI];
  logic [1:0]  ch_sel    [NI];
  logic        sample_en [NI];
  logic [11:0] sample_idx[NI];
  logic        done      [NI];

  sample_sequencer #(.NUM_CH(4), .DIV_W(16), .CNT_W(12), .SETTLE(15)) u0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .div_cfg(div_cfg),
    .n_samples(n_samples), .ch_mask(ch_mask), .busy(busy[0]), .ch_sel(ch_sel[0]),
    .sample_en(sample_en[0]), .sample_idx(sample_idx[0]), .done(done[0]));

  sample_sequencer #(.NUM_CH(4), .DIV_W(16), .CNT_W(12), .SETTLE(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .div_cfg(div_cfg),
    .n_samples(n_samples), .ch_mask(ch_mask), .busy(busy[1]), .ch_sel(ch_sel[1]),
    .sample_en(sample_en[1]), .sample_idx(sample_idx[1]), .done(done[1]));

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int inst; int t; int ch; int idx; } ev_t;
  ev_t evq[$];
  int  bs[NI], be[NI], ed[NI];
  int  errors = 0, checks = 0;
  bit  mon_en = 0;

  function automatic int settle_of(int i);
    return (i == 0) ? 15 : 0;
  endfunction

  // Expected behaviour of a start sampled at edge e, per instance.
  task automatic model_start(int e, logic [3:0] m, int n, int d, bit ab);
    for (int i = 0; i < NI; i++) begin
      int s, t, ts;
      bit first;
      if (m == 0 || n == 0 || ab || (e - 1 <= be[i])) continue;
      s = settle_of(i); first = 1; t = 0; ts = 0;
      for (int ch = 0; ch < 4; ch++) begin
        if (!m[ch]) continue;
        t = first ? (e + s + d) : (ts + 2 + s + d);
        for (int k = 0; k < n; k++) evq.push_back('{i, t + k * (d + 1), ch, k});
        ts = t + (n - 1) * (d + 1);
        first = 0;
      end
      bs[i] = e; be[i] = ts + 2; ed[i] = ts + 2;
    end
  endtask

  // Abort sampled at edge a: nothing expected from cycle a onward.
  task automatic model_abort(int a);
    for (int i = 0; i < NI; i++) begin
      if (a - 1 >= bs[i] && a - 1 <= be[i]) begin
        be[i] = a - 1;
        if (ed[i] >= a) ed[i] = -10;
        for (int j = evq.size() - 1; j >= 0; j--)
          if (evq[j].inst == i && evq[j].t >= a) evq.delete(j);
      end
    end
  endtask

  task automatic issue(logic [3:0] m, int n, int d, bit ab);
    ch_mask = m; n_samples = 12'(n); div_cfg = 16'(d); start = 1'b1; abort = ab;
    model_start(cyc + 1, m, n, d, ab);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    model_abort(cyc + 1);
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic gap(int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  // Returns in the first cycle both instances are expected idle.
  task automatic wait_idle();
    while (cyc <= be[0] || cyc <= be[1]) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin
        int  fi;
        bit  eb;
        fi = -1;
        for (int j = 0; j < evq.size(); j++)
          if (evq[j].inst == i) begin fi = j; break; end
        if (sample_en[i]) begin
          checks++;
          if (fi < 0 || evq[fi].t != cyc || evq[fi].ch != int'(ch_sel[i]) ||
              evq[fi].idx != int'(sample_idx[i])) begin
            errors++;
            if (fi < 0)
              $display("FAIL strobe u%0d cyc=%0d got ch=%0d idx=%0d, none expected",
                       i, cyc, ch_sel[i], sample_idx[i]);
            else
              $display("FAIL strobe u%0d cyc=%0d got ch=%0d idx=%0d, want cyc=%0d ch=%0d idx=%0d",
                       i, cyc, ch_sel[i], sample_idx[i], evq[fi].t, evq[fi].ch, evq[fi].idx);
          end
          if (fi >= 0 && evq[fi].t == cyc) evq.delete(fi);
        end else if (fi >= 0 && evq[fi].t <= cyc) begin
          checks++; errors++;
          $display("FAIL missing_strobe u%0d cyc=%0d got none, want ch=%0d idx=%0d at cyc=%0d",
                   i, cyc, evq[fi].ch, evq[fi].idx, evq[fi].t);
          evq.delete(fi);
        end
        checks++;
        if (done[i] !== (cyc == ed[i])) begin
          errors++;
          $display("FAIL done u%0d cyc=%0d got %0b want %0b", i, cyc, done[i], cyc == ed[i]);
        end
        eb = (cyc >= bs[i]) && (cyc <= be[i]);
        checks++;
        if (busy[i] !== eb) begin
          errors++;
          $display("FAIL busy u%0d cyc=%0d got %0b want %0b", i, cyc, busy[i], eb);
        end
      end
    end
  end

  initial begin
    int e;
    for (int i = 0; i < NI; i++) begin bs[i] = 0; be[i] = -10; ed[i] = -10; end
    rst = 1'b1; start = 1'b1; abort = 1'b0;
    ch_mask = 4'h1; n_samples = 12'd3; div_cfg = 16'd0;

    // Reset holds everything at zero even with start asserted.
    repeat (3) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (busy[i] !== 1'b0 || sample_en[i] !== 1'b0 || done[i] !== 1'b0 ||
            ch_sel[i] !== 2'd0 || sample_idx[i] !== 12'd0) begin
          errors++;
          $display("FAIL reset u%0d got busy=%0b en=%0b done=%0b ch=%0d idx=%0d want all 0",
                   i, busy[i], sample_en[i], done[i], ch_sel[i], sample_idx[i]);
        end
      end
    end
    rst = 1'b0; start = 1'b0;
    mon_en = 1;
    gap(2);

    // Single channel, then a start with different config while busy.
    issue(4'b0001, 3, 4, 0);
    gap(6);
    issue(4'b1111, 3, 1, 0);
    wait_idle();

    // Mask skip, back-to-back strobes.
    issue(4'b1010, 2, 0, 0);
    wait_idle();

    // Invalid starts, then an immediate valid one.
    issue(4'b0000, 3, 2, 0);
    gap(3);
    issue(4'b0101, 0, 2, 0);
    issue(4'b0101, 1, 1, 0);
    wait_idle();

    // Start together with abort in IDLE is ignored.
    issue(4'b0011, 2, 1, 1);
    gap(3);

    // Abort sampled on the edge that would produce u0's second strobe.
    e = cyc + 1;
    issue(4'b0011, 4, 3, 0);
    while (cyc < e + 21) begin @(posedge clk); #1; end
    pulse_abort();
    wait_idle();
    issue(4'b0010, 2, 1, 0);
    wait_idle();

    // Randomised sequences with occasional aborts.
    for (int r = 0; r < 40; r++) begin
      issue(4'($urandom_range(0, 15)), $urandom_range(0, 4), $urandom_range(0, 5), 0);
      if ($urandom_range(0, 3) == 0) begin
        gap($urandom_range(0, 30));
        pulse_abort();
      end
      wait_idle();
      gap($urandom_range(0, 2));
    end
    gap(3);

    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL leftover_strobes got %0d outstanding want 0", evq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
